// File: rtl/can_frame_rx.sv
// can_frame_rx: CAN 2.0A receiver with bit timing, de-stuffing, CRC-15 check, ACK drive and parallel frame output.
// Optional acceptance filter (filt_id/filt_mask ports) is enabled by defining CAN_RX_ID_FILTER_EN.
module can_frame_rx #(
  parameter int unsigned BIT_DIV   = 20,
  parameter int unsigned SAMPLE_PT = 14
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        can_hi_in,
`ifdef CAN_RX_ID_FILTER_EN
  input  logic [10:0] filt_id,
  input  logic [10:0] filt_mask,
`endif
  output logic        can_hi_out,
  output logic        rx_busy,
  output logic        rx_valid,
  output logic [10:0] rx_id,
  output logic        rx_rtr,
  output logic [3:0]  rx_dlc,
  output logic [63:0] rx_data,
  output logic        rx_err,
  output logic [1:0]  rx_err_code
);
  localparam int unsigned CW = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
  localparam logic [1:0] ERR_STUFF = 2'd1;
  localparam logic [1:0] ERR_CRC   = 2'd2;
  localparam logic [1:0] ERR_FORM  = 2'd3;

  typedef enum logic [3:0] {
    S_WAIT_IDLE, S_IDLE, S_ARB, S_CTRL, S_DATA, S_CRC, S_CRC_DEL, S_ACK, S_ACK_DEL, S_EOF
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, ack_tmr;
  logic          bus_q, rise, smp, b;
  logic [6:0]    fcnt;
  logic [2:0]    run;
  logic          last;
  logic [10:0]   id_sh;
  logic          rtr_sh;
  logic [3:0]    dlc_sh, dlc_full, nbytes;
  logic [2:0]    nbytes_m1;
  logic [6:0]    data_last;
  logic [63:0]   data_sh;
  logic [14:0]   crc_calc, crc_rx;
  logic          ack_sent;
  logic          stuff_zone, stuff_bit, err, done, accept;
  logic [1:0]    err_code;

  function automatic logic [14:0] crc_step(input logic [14:0] c, input logic d);
    crc_step = {c[13:0], 1'b0} ^ ((d ^ c[14]) ? 15'h4599 : 15'h0000);
  endfunction

  // b is the logical bit value: dominant bus level is logic 0
  assign rise       = can_hi_in & ~bus_q;
  assign smp        = (cnt == CW'(SAMPLE_PT));
  assign b          = ~can_hi_in;
  assign stuff_zone = state inside {S_ARB, S_CTRL, S_DATA, S_CRC, S_CRC_DEL};
  assign stuff_bit  = smp && stuff_zone && (run == 3'd5);
  assign dlc_full   = {dlc_sh[2:0], b};
  assign nbytes     = (dlc_sh > 4'd8) ? 4'd8 : dlc_sh;
  assign nbytes_m1  = 3'(nbytes - 4'd1);
  assign data_last  = {1'b0, nbytes_m1, 3'b111};

`ifdef CAN_RX_ID_FILTER_EN
  assign accept = (((id_sh ^ filt_id) & filt_mask) == 11'd0);
`else
  assign accept = 1'b1;
`endif

  // Bit timing: free-running bit counter, resynced on every recessive->dominant edge
  always_ff @(posedge CLK) begin
    if (RST) begin
      bus_q <= 1'b0;
      cnt   <= '0;
    end else begin
      bus_q <= can_hi_in;
      if (rise || cnt == CW'(BIT_DIV - 1)) cnt <= '0;
      else                                  cnt <= cnt + CW'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) state <= S_WAIT_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n  = state;
    err      = 1'b0;
    err_code = 2'd0;
    done     = 1'b0;
    if (smp) begin
      if (stuff_bit) begin
        if (b == last) begin
          err      = 1'b1;
          err_code = ERR_STUFF;
        end
      end else begin
        unique case (state)
          S_WAIT_IDLE: if (b && fcnt == 7'd10) state_n = S_IDLE;
          S_IDLE:      if (!b) state_n = S_ARB;
          S_ARB:       if (fcnt == 7'd11) state_n = S_CTRL;
          S_CTRL: begin
            if (fcnt == 7'd0 && b) begin
              err      = 1'b1;
              err_code = ERR_FORM;
            end else if (fcnt == 7'd5) begin
              state_n = (!rtr_sh && dlc_full != 4'd0) ? S_DATA : S_CRC;
            end
          end
          S_DATA:      if (fcnt == data_last) state_n = S_CRC;
          S_CRC:       if (fcnt == 7'd14) state_n = S_CRC_DEL;
          S_CRC_DEL: begin
            if (crc_rx != crc_calc) begin
              err      = 1'b1;
              err_code = ERR_CRC;
            end else if (!b) begin
              err      = 1'b1;
              err_code = ERR_FORM;
            end else begin
              state_n = S_ACK;
            end
          end
          S_ACK:       state_n = S_ACK_DEL;
          S_ACK_DEL: begin
            if (!b) begin
              err      = 1'b1;
              err_code = ERR_FORM;
            end else begin
              state_n = S_EOF;
            end
          end
          S_EOF: begin
            if (!b) begin
              err      = 1'b1;
              err_code = ERR_FORM;
            end else if (fcnt == 7'd6) begin
              state_n = S_IDLE;
              done    = 1'b1;
            end
          end
          default: state_n = S_WAIT_IDLE;
        endcase
      end
      if (err) state_n = S_WAIT_IDLE;
    end
  end

  // Field shift registers, de-stuff run tracking and CRC accumulation
  always_ff @(posedge CLK) begin
    if (RST) begin
      fcnt     <= '0;
      run      <= '0;
      last     <= 1'b1;
      id_sh    <= '0;
      rtr_sh   <= 1'b0;
      dlc_sh   <= '0;
      data_sh  <= '0;
      crc_calc <= '0;
      crc_rx   <= '0;
    end else begin
      if (err) begin
        fcnt <= '0;
      end else if (smp && !stuff_bit) begin
        if (state_n != state || (state == S_WAIT_IDLE && !b)) fcnt <= '0;
        else                                                  fcnt <= fcnt + 7'd1;
      end
      if (smp && (stuff_zone || state == S_IDLE)) begin
        if (stuff_bit || state == S_IDLE || b != last) run <= 3'd1;
        else                                           run <= run + 3'd1;
        last <= b;
      end
      if (smp && !stuff_bit) begin
        unique case (state)
          S_IDLE: if (!b) begin
            crc_calc <= crc_step(15'd0, b);
            data_sh  <= '0;
          end
          S_ARB: begin
            crc_calc <= crc_step(crc_calc, b);
            if (fcnt < 7'd11) id_sh <= {id_sh[9:0], b};
            else              rtr_sh <= b;
          end
          S_CTRL: begin
            crc_calc <= crc_step(crc_calc, b);
            if (fcnt >= 7'd2) dlc_sh <= dlc_full;
          end
          S_DATA: begin
            crc_calc <= crc_step(crc_calc, b);
            data_sh[6'(7'd63 - fcnt)] <= b;
          end
          S_CRC:   crc_rx <= {crc_rx[13:0], b};
          default: ;
        endcase
      end
    end
  end

  // Registered outputs and the one-bit-time ACK drive
  always_ff @(posedge CLK) begin
    if (RST) begin
      can_hi_out  <= 1'b0;
      ack_tmr     <= '0;
      ack_sent    <= 1'b0;
      rx_busy     <= 1'b0;
      rx_valid    <= 1'b0;
      rx_id       <= '0;
      rx_rtr      <= 1'b0;
      rx_dlc      <= '0;
      rx_data     <= '0;
      rx_err      <= 1'b0;
      rx_err_code <= '0;
    end else begin
      rx_valid <= done && accept;
      rx_err   <= err;
      rx_busy  <= state_n inside {S_ARB, S_CTRL, S_DATA, S_CRC, S_CRC_DEL, S_ACK, S_ACK_DEL, S_EOF};
      if (err) rx_err_code <= err_code;
      if (done && accept) begin
        rx_id   <= id_sh;
        rx_rtr  <= rtr_sh;
        rx_dlc  <= dlc_sh;
        rx_data <= data_sh;
      end
      if (err) begin
        can_hi_out <= 1'b0;
      end else if (can_hi_out) begin
        if (ack_tmr == '0) can_hi_out <= 1'b0;
        else               ack_tmr    <= ack_tmr - CW'(1);
      end else if (state == S_ACK && !ack_sent && (rise || cnt == CW'(BIT_DIV - 1))) begin
        can_hi_out <= 1'b1;
        ack_sent   <= 1'b1;
        ack_tmr    <= CW'(BIT_DIV - 1);
      end
      if (state == S_IDLE) ack_sent <= 1'b0;
    end
  end
endmodule
